if_fetch_ctrl: RTL
==================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter pc_size, default 18, PC / instruction-address width.
REQ-002 Parameter inst_size, default 32, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-low reset; sampled on the clk rising edge.
REQ-005 pc  input  pc_size  current PC from the PC register; reflects a pc_write update by the next rising clk edge (PC register clocked on falling edge).
REQ-006 flush  input  1  branch/jump taken; current fetch is discarded.
REQ-007 id_stall  input  1  ID stage cannot accept an instruction this cycle.
REQ-008 imem_req  output  1  instruction-memory request, level, held until imem_ack.
REQ-009 imem_addr  output  pc_size  request address, stable while imem_req=1.
REQ-010 imem_ack  input  1  memory returns imem_rdata this cycle; ignored when no request is outstanding.
REQ-011 imem_rdata  input  inst_size  returned instruction word.
REQ-012 pc_write  output  1  one-cycle PC-update enable pulse.
REQ-013 inst_out  output  inst_size  fetched instruction to IF/ID.
REQ-014 inst_valid  output  1  inst_out holds an unconsumed instruction.

Function
REQ-015 All outputs SHALL be registered; FSM states: IDLE, WAIT, HOLD, DROP.
REQ-016 Each transition SHALL take effect at the clk edge where its condition is sampled; flush SHALL have priority over every other condition.
REQ-017 IDLE, flush=0: next WAIT; imem_req<=1; imem_addr<=pc.
REQ-018 IDLE, flush=1: stay IDLE; pc_write<=1.
REQ-019 WAIT: imem_req=1 and imem_addr SHALL be held unchanged until the ack cycle.
REQ-020 WAIT, imem_ack=1, flush=0: next HOLD; inst_out<=imem_rdata; inst_valid<=1; pc_write<=1; imem_req<=0.
REQ-021 WAIT, imem_ack=1, flush=1: next IDLE; imem_rdata discarded (inst_out, inst_valid unchanged); pc_write<=1; imem_req<=0.
REQ-022 WAIT, imem_ack=0, flush=1: next DROP; pc_write<=1; imem_req stays 1 (memory requests are not abortable).
REQ-023 DROP, imem_ack=1: next IDLE; data discarded; imem_req<=0; a flush in the same cycle SHALL also set pc_write<=1.
REQ-024 DROP, imem_ack=0: stay DROP; each flush sets pc_write<=1.
REQ-025 HOLD, flush=1: next IDLE; inst_valid<=0; pc_write<=1.
REQ-026 HOLD, flush=0, id_stall=1: stay HOLD; inst_out and inst_valid unchanged; imem_req=0.
REQ-027 HOLD, flush=0, id_stall=0: instruction consumed; next WAIT; inst_valid<=0; imem_req<=1; imem_addr<=pc (already-updated PC).
REQ-028 pc_write SHALL be high for exactly one cycle per triggering event and 0 otherwise; it SHALL never be high in a cycle where a new request is launched.
REQ-029 At most one request SHALL be outstanding; imem_ack in IDLE or HOLD SHALL be ignored with no state or output change.
REQ-030 inst_valid SHALL never assert for data whose request was outstanding when flush or reset occurred.

Reset
REQ-031 rst=0 at a rising edge SHALL force state IDLE, imem_req=0, imem_addr=0, pc_write=0, inst_valid=0, inst_out=0, regardless of state, including an outstanding request.
REQ-032 The first request SHALL launch at the first rising edge with rst=1 and flush=0.

Verification
REQ-033 rst=0 for 2 cycles, then rst=1 with pc=0x00004 -> outputs all 0 during reset; next edge imem_req=1, imem_addr=0x00004.
REQ-034 imem_ack with imem_rdata=0x8C220004 three cycles after request -> next cycle inst_valid=1, inst_out=0x8C220004, pc_write=1 for one cycle, imem_req=0.
REQ-035 id_stall=1 for 2 cycles in HOLD -> inst_out/inst_valid stable, imem_req=0, pc_write=0; id_stall=0 with pc=0x00008 -> next edge imem_req=1, imem_addr=0x00008, inst_valid=0.
REQ-036 flush in WAIT before ack, ack 2 cycles later with 0xDEADBEEF -> one pc_write pulse, imem_req held through ack, 0xDEADBEEF never on inst_out with inst_valid=1; then request at the target pc.
REQ-037 imem_ack and flush in the same WAIT cycle -> data discarded, pc_write pulse, IDLE, new request the following edge.
REQ-038 rst=0 during WAIT, imem_ack arrives while in IDLE with rst=1 and flush=1 -> ack ignored, inst_valid stays 0.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction fetch controller between PC register, instruction memory and IF/ID
// Issues one memory request at a time, holds the returned word for ID, and squashes fetches on flush.
module if_fetch_ctrl #(
  parameter int pc_size   = 18,
  parameter int inst_size = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [pc_size-1:0]   pc,
  input  logic                 flush,
  input  logic                 id_stall,
  output logic                 imem_req,
  output logic [pc_size-1:0]   imem_addr,
  input  logic                 imem_ack,
  input  logic [inst_size-1:0] imem_rdata,
  output logic                 pc_write,
  output logic [inst_size-1:0] inst_out,
  output logic                 inst_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 imem_req_q, imem_req_d;
  logic [pc_size-1:0]   imem_addr_q, imem_addr_d;
  logic                 pc_write_q, pc_write_d;
  logic [inst_size-1:0] inst_out_q, inst_out_d;
  logic                 inst_valid_q, inst_valid_d;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!flush) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_ack && flush)  state_d = S_IDLE;
        else if (flush)         state_d = S_DROP;
        else if (imem_ack)      state_d = S_HOLD;
      end
      S_HOLD: begin
        if (flush)          state_d = S_IDLE;
        else if (!id_stall) state_d = S_WAIT;
      end
      S_DROP: if (imem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A flushed request stays on the bus until the memory answers; only its data is thrown away.
  always_comb begin
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    pc_write_d   = 1'b0;
    inst_out_d   = inst_out_q;
    inst_valid_d = inst_valid_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          pc_write_d = 1'b1;
        end else begin
          imem_req_d  = 1'b1;
          imem_addr_d = pc;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          pc_write_d = 1'b1;
          if (!flush) begin
            inst_out_d   = imem_rdata;
            inst_valid_d = 1'b1;
          end
        end else if (flush) begin
          pc_write_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          inst_valid_d = 1'b0;
          pc_write_d   = 1'b1;
        end else if (!id_stall) begin
          inst_valid_d = 1'b0;
          imem_req_d   = 1'b1;
          imem_addr_d  = pc;
        end
      end
      S_DROP: begin
        pc_write_d = flush;
        if (imem_ack) imem_req_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      pc_write_q   <= 1'b0;
      inst_out_q   <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      pc_write_q   <= pc_write_d;
      inst_out_q   <= inst_out_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign pc_write   = pc_write_q;
  assign inst_out   = inst_out_q;
  assign inst_valid = inst_valid_q;

endmodule
